// File: rtl/debug_controller_pkg.sv
// Shared opcodes, reply bytes and FSM encoding for the pipeline debug port.
// DBG_CYCLE_COUNTER_EN enables the OP_CYCLES counter readback.
package debug_controller_pkg;

    localparam logic [5:0] OP_STEP   = 6'h3F;
    localparam logic [5:0] OP_RUN    = 6'h3E;
    localparam logic [5:0] OP_PING   = 6'h38;
    localparam logic [5:0] OP_CYCLES = 6'h3C;

    localparam logic [7:0] ACK_BYTE  = 8'hFF;
    localparam logic [7:0] PING_BYTE = 8'h55;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PULSE,
        S_RUN,
        S_SETTLE,
        S_LATCH,
        S_SEND
    } state_t;

endpackage

// File: rtl/dbg_tx_serializer.sv
// Byte serializer: loads a word plus byte count and shifts it out LSB first
// over a valid/ready handshake, pulsing done_o on the final transfer.
module dbg_tx_serializer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_ni,
    input  logic         load_i,
    input  logic [W-1:0] word_i,
    input  logic [1:0]   cnt_i,
    input  logic         tx_ready_i,
    output logic [7:0]   tx_data_o,
    output logic         tx_valid_o,
    output logic         done_o
);

    logic [W-1:0] shift_q;
    logic [1:0]   cnt_q;
    logic         valid_q;
    logic         xfer;

    assign xfer       = valid_q & tx_ready_i;
    assign done_o     = xfer & (cnt_q == 2'd0);
    assign tx_data_o  = shift_q[7:0];
    assign tx_valid_o = valid_q;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            shift_q <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (load_i) begin
            shift_q <= word_i;
            cnt_q   <= cnt_i;
            valid_q <= 1'b1;
        end else if (xfer) begin
            if (cnt_q == 2'd0) begin
                valid_q <= 1'b0;
            end else begin
                shift_q <= shift_q >> 8;
                cnt_q   <= cnt_q - 2'd1;
            end
        end
    end

endmodule

// File: rtl/debug_controller.sv
// Debug-port command sequencer: step/run gating, probe readback, ping.
// DBG_CYCLE_COUNTER_EN adds a cpu_en cycle counter read by OP_CYCLES.
module debug_controller
    import debug_controller_pkg::*;
#(
    parameter int PROBE_W = 32,
    parameter int SEL_W   = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    input  logic               tx_ready,
    output logic [7:0]         tx_data,
    output logic               tx_valid,
    output logic [SEL_W-1:0]   probe_sel,
    input  logic [PROBE_W-1:0] probe_data,
    output logic               cpu_en,
    output logic               busy,
    output logic               err_overrun
);

    logic [5:0]         op;
    logic [1:0]         size;
    state_t             state_q;
    logic               cpu_en_q;
    logic               err_q;
    logic [SEL_W-1:0]   sel_q;
    logic [1:0]         size_q;
    logic               ld_d;
    logic [PROBE_W-1:0] word_d;
    logic [1:0]         cnt_d;
    logic               done;

    assign op          = rx_data[5:0];
    assign size        = rx_data[7:6];
    assign cpu_en      = cpu_en_q;
    assign probe_sel   = sel_q;
    assign err_overrun = err_q;
    assign busy        = (state_q != S_IDLE);

`ifdef DBG_CYCLE_COUNTER_EN
    logic [31:0] cyc_q;
    logic        is_cyc_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        cyc_q <= '0;
        else if (cpu_en_q) cyc_q <= cyc_q + 32'd1;
    end
`endif

    always_comb begin
        ld_d   = 1'b0;
        word_d = '0;
        cnt_d  = '0;
        unique case (state_q)
            S_IDLE: begin
                ld_d   = rx_valid && (op == OP_PING);
                word_d = PROBE_W'(PING_BYTE);
            end
            S_PULSE: begin
                ld_d   = 1'b1;
                word_d = PROBE_W'(ACK_BYTE);
            end
            S_LATCH: begin
                ld_d  = 1'b1;
                cnt_d = size_q;
`ifdef DBG_CYCLE_COUNTER_EN
                word_d = is_cyc_q ? PROBE_W'(cyc_q) : probe_data;
`else
                word_d = probe_data;
`endif
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cpu_en_q <= 1'b0;
            err_q    <= 1'b0;
            sel_q    <= '0;
            size_q   <= '0;
`ifdef DBG_CYCLE_COUNTER_EN
            is_cyc_q <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                S_IDLE: if (rx_valid) begin
                    unique case (1'b1)
                        op == OP_STEP: begin
                            state_q  <= S_PULSE;
                            cpu_en_q <= 1'b1;
                        end
                        op == OP_RUN: begin
                            state_q  <= S_RUN;
                            cpu_en_q <= 1'b1;
                        end
                        op == OP_PING: state_q <= S_SEND;
                        default: begin
                            state_q <= S_SETTLE;
                            sel_q   <= SEL_W'(op);
                            size_q  <= size;
`ifdef DBG_CYCLE_COUNTER_EN
                            is_cyc_q <= (op == OP_CYCLES);
`endif
                        end
                    endcase
                end
                S_PULSE: begin
                    cpu_en_q <= 1'b0;
                    state_q  <= S_SEND;
                end
                // The halting byte is consumed here and never decoded
                S_RUN: if (rx_valid) begin
                    cpu_en_q <= 1'b0;
                    state_q  <= S_IDLE;
                end
                S_SETTLE: state_q <= S_LATCH;
                S_LATCH:  state_q <= S_SEND;
                S_SEND:   if (done) state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
            if (rx_valid && (state_q inside {S_PULSE, S_SETTLE,
                                             S_LATCH, S_SEND}))
                err_q <= 1'b1;
        end
    end

    dbg_tx_serializer #(
        .W(PROBE_W)
    ) u_ser (
        .clk        (clk),
        .rst_ni     (reset),
        .load_i     (ld_d),
        .word_i     (word_d),
        .cnt_i      (cnt_d),
        .tx_ready_i (tx_ready),
        .tx_data_o  (tx_data),
        .tx_valid_o (tx_valid),
        .done_o     (done)
    );

endmodule

// File: tb/tb_debug_controller.sv
// Directed bench for debug_controller: probe reads, step, run, ping,
// stall/overrun, async reset, back-to-back and OP_CYCLES handling.
module tb_debug_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic [5:0]  probe_sel;
    logic [31:0] probe_data;
    logic        cpu_en;
    logic        busy;
    logic        err_overrun;

    int n_checks = 0;
    int n_fail   = 0;

    debug_controller #(.PROBE_W(32), .SEL_W(6)) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .tx_ready    (tx_ready),
        .tx_data     (tx_data),
        .tx_valid    (tx_valid),
        .probe_sel   (probe_sel),
        .probe_data  (probe_data),
        .cpu_en      (cpu_en),
        .busy        (busy),
        .err_overrun (err_overrun)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0; rx_data = '0; rx_valid = 1'b0;
        tx_ready = 1'b1; probe_data = '0;
        #1;
        n_checks++;
        if ({tx_valid, tx_data, probe_sel, cpu_en, busy, err_overrun} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_hold: got %h expected 0",
                     {tx_valid, tx_data, probe_sel, cpu_en, busy, err_overrun});
        end
        tick(); tick();
        reset = 1'b1;
        tick();
        n_checks++;
        if ({tx_valid, tx_data, probe_sel, cpu_en, busy, err_overrun} !== 18'd0) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected 0",
                     {tx_valid, tx_data, probe_sel, cpu_en, busy, err_overrun});
        end
    endtask

    task automatic test_probe_read();
        logic [7:0] exp [4] = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
        probe_data = 32'hDEADBEEF; tx_ready = 1'b1;
        rx_data = 8'hC1; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (probe_sel !== 6'd1 || busy !== 1'b1 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL probe_settle: sel=%h busy=%b txv=%b expected 01 1 0",
                     probe_sel, busy, tx_valid);
        end
        tick();
        n_checks++;
        if (tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL probe_latency2: txv=%b expected 0", tx_valid);
        end
        tick();
        probe_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                n_fail++;
                $display("FAIL probe_byte%0d: txv=%b data=%h expected 1 %h",
                         i, tx_valid, tx_data, exp[i]);
            end
            tick();
        end
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL probe_end: txv=%b busy=%b expected 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_step();
        rx_data = 8'h3F; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (cpu_en !== 1'b1 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL step_pulse: cpu_en=%b txv=%b expected 1 0", cpu_en, tx_valid);
        end
        tick();
        n_checks++;
        if (cpu_en !== 1'b0 || tx_valid !== 1'b1 || tx_data !== 8'hFF) begin
            n_fail++;
            $display("FAIL step_ack: cpu_en=%b txv=%b data=%h expected 0 1 ff",
                     cpu_en, tx_valid, tx_data);
        end
        tick();
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL step_end: txv=%b busy=%b cpu_en=%b expected 0 0 0",
                     tx_valid, busy, cpu_en);
        end
    endtask

    task automatic test_run();
        int on_cnt = 0;
        rx_data = 8'h3E; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (cpu_en === 1'b1) on_cnt++;
            tick();
        end
        n_checks++;
        if (on_cnt !== 10 || cpu_en !== 1'b1) begin
            n_fail++;
            $display("FAIL run_enable: cycles=%0d cpu_en=%b expected 10 1", on_cnt, cpu_en);
        end
        rx_data = 8'h00; rx_valid = 1'b1;
        #1;
        n_checks++;
        if (cpu_en !== 1'b1) begin
            n_fail++;
            $display("FAIL run_strobe_cycle: cpu_en=%b expected 1", cpu_en);
        end
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (cpu_en !== 1'b0 || busy !== 1'b0 || tx_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_halt: cpu_en=%b busy=%b txv=%b expected 0 0 0",
                     cpu_en, busy, tx_valid);
        end
        tick(); tick(); tick();
        n_checks++;
        if (tx_valid !== 1'b0 || probe_sel !== 6'd1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL run_discard: txv=%b sel=%h busy=%b expected 0 01 0",
                     tx_valid, probe_sel, busy);
        end
    endtask

    task automatic test_ping();
        rx_data = 8'hF8; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h55) begin
            n_fail++;
            $display("FAIL ping_reply: txv=%b data=%h expected 1 55", tx_valid, tx_data);
        end
        tick();
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ping_end: txv=%b busy=%b expected 0 0", tx_valid, busy);
        end
    endtask

    task automatic test_stall_overrun();
        probe_data = 32'h12345678; tx_ready = 1'b0;
        rx_data = 8'h41; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(); tick();
        probe_data = 32'hFFFFFFFF;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== 8'h78) begin
                n_fail++;
                $display("FAIL stall_hold%0d: txv=%b data=%h expected 1 78",
                         i, tx_valid, tx_data);
            end
            if (i == 0) begin
                rx_data = 8'h3F; rx_valid = 1'b1;
            end
            tick();
            rx_valid = 1'b0;
        end
        n_checks++;
        if (err_overrun !== 1'b1 || cpu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_flag: err=%b cpu_en=%b expected 1 0", err_overrun, cpu_en);
        end
        tx_ready = 1'b1;
        tick();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h56) begin
            n_fail++;
            $display("FAIL stall_byte1: txv=%b data=%h expected 1 56", tx_valid, tx_data);
        end
        tick();
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_end: txv=%b busy=%b expected 0 0", tx_valid, busy);
        end
        tick(); tick();
        n_checks++;
        if (tx_valid !== 1'b0 || cpu_en !== 1'b0 || err_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_dropped: txv=%b cpu_en=%b err=%b expected 0 0 1",
                     tx_valid, cpu_en, err_overrun);
        end
    endtask

    task automatic test_reset_mid();
        probe_data = 32'hA5A5A5A5; tx_ready = 1'b0;
        rx_data = 8'hC3; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(); tick();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || err_overrun !== 1'b0
            || tx_data !== 8'h00 || probe_sel !== 6'd0) begin
            n_fail++;
            $display("FAIL reset_mid_send: txv=%b busy=%b err=%b data=%h sel=%h expected 0 0 0 00 00",
                     tx_valid, busy, err_overrun, tx_data, probe_sel);
        end
        tick();
        reset = 1'b1; tx_ready = 1'b1;
        tick();
        rx_data = 8'h3E; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick();
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if (cpu_en !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_run: cpu_en=%b busy=%b expected 0 0", cpu_en, busy);
        end
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_back_to_back();
        probe_data = 32'hAABBCCDD; tx_ready = 1'b1;
        rx_data = 8'h02; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hDD || probe_sel !== 6'd2) begin
            n_fail++;
            $display("FAIL size0_byte: txv=%b data=%h sel=%h expected 1 dd 02",
                     tx_valid, tx_data, probe_sel);
        end
        tick();
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL size0_end: txv=%b busy=%b expected 0 0", tx_valid, busy);
        end
        probe_data = 32'h11223344;
        rx_data = 8'h45; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        tick(); tick();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h44 || probe_sel !== 6'd5) begin
            n_fail++;
            $display("FAIL b2b_byte0: txv=%b data=%h sel=%h expected 1 44 05",
                     tx_valid, tx_data, probe_sel);
        end
        tick();
        n_checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'h33) begin
            n_fail++;
            $display("FAIL b2b_byte1: txv=%b data=%h expected 1 33", tx_valid, tx_data);
        end
        tick();
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0 || err_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_end: txv=%b busy=%b err=%b expected 0 0 0",
                     tx_valid, busy, err_overrun);
        end
    endtask

    task automatic test_cycles();
        logic [7:0] exp [4];
        reset = 1'b0;
        tick();
        reset = 1'b1; tx_ready = 1'b1;
        tick();
        for (int s = 0; s < 3; s++) begin
            rx_data = 8'h3F; rx_valid = 1'b1;
            tick();
            rx_valid = 1'b0;
            tick(); tick(); tick();
        end
        probe_data = 32'hCAFEF00D;
`ifdef DBG_CYCLE_COUNTER_EN
        exp = '{8'h03, 8'h00, 8'h00, 8'h00};
`else
        exp = '{8'h0D, 8'hF0, 8'hFE, 8'hCA};
`endif
        rx_data = 8'hFC; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
`ifndef DBG_CYCLE_COUNTER_EN
        n_checks++;
        if (probe_sel !== 6'h3C) begin
            n_fail++;
            $display("FAIL cycles_sel: sel=%h expected 3c", probe_sel);
        end
`endif
        tick(); tick();
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (tx_valid !== 1'b1 || tx_data !== exp[i]) begin
                n_fail++;
                $display("FAIL cycles_byte%0d: txv=%b data=%h expected 1 %h",
                         i, tx_valid, tx_data, exp[i]);
            end
            tick();
        end
        n_checks++;
        if (tx_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cycles_end: txv=%b busy=%b expected 0 0", tx_valid, busy);
        end
    endtask

    initial begin
        test_reset();
        test_probe_read();
        test_step();
        test_run();
        test_ping();
        test_stall_overrun();
        test_reset_mid();
        test_back_to_back();
        test_cycles();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
